// File: rtl/cmos_emu_pkg.sv
// rtl/cmos_emu_pkg.sv - shared types and constants for the CMOS sensor emulator
//
// Purpose : frame FSM state encoding, test-pattern encodings, LFSR seed/taps
//           and the LFSR step function used by the pattern generator.
// Ports   : none (package)
package cmos_emu_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_VS_LEAD    = 3'd1,
    S_LINE_ACT   = 3'd2,
    S_LINE_BLANK = 3'd3,
    S_VS_TAIL    = 3'd4,
    S_V_BLANK    = 3'd5
  } emu_state_t;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_FRAME = 2'd3;

  // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from register bits 7, 5, 4, 3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cmos_sensor_emu_if.sv
// rtl/cmos_sensor_emu_if.sv - 8-bit parallel DVP sensor bus
//
// Purpose : groups the sensor-side bus signals.
// Signals : cmos_vsync - high for the whole frame
//           cmos_href  - high during active pixels
//           cmos_data  - pixel byte, 8'h00 while href is low
// Modports: master (sensor/emulator drives), slave (capture path receives)
interface cmos_sensor_emu_if;
  logic       cmos_vsync;
  logic       cmos_href;
  logic [7:0] cmos_data;

  modport master (output cmos_vsync, output cmos_href, output cmos_data);
  modport slave  (input  cmos_vsync, input  cmos_href, input  cmos_data);
endinterface

// File: rtl/cmos_emu_pattern_gen.sv
// rtl/cmos_emu_pattern_gen.sv - next-pixel test pattern generator
//
// Purpose : combinationally forms the data byte that will be registered onto
//           the bus together with href; owns the LFSR when CMOS_EMU_LFSR_EN
//           is defined (pattern 3 = LFSR), otherwise pattern 3 = frame count.
// Ports   : i_clk, i_rst   - pixel clock / async active-high reset (LFSR only)
//           i_seed         - reload LFSR with the seed (vsync rising edge)
//           i_frame_cnt    - completed-frame count low byte (no LFSR build)
//           i_x, i_y       - low bytes of pixel / line position
//           i_pat          - pattern latched for the current frame
//           i_href_next    - href value being registered this cycle
//           o_data_next    - data value being registered this cycle
module cmos_emu_pattern_gen
  import cmos_emu_pkg::*;
(
`ifdef CMOS_EMU_LFSR_EN
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_seed,
`else
  input  logic [7:0] i_frame_cnt,
`endif
  input  logic [7:0] i_x,
  input  logic [7:0] i_y,
  input  logic [1:0] i_pat,
  input  logic       i_href_next,
  output logic [7:0] o_data_next
);

  logic [7:0] w_pix;
  logic [7:0] w_fill;

`ifdef CMOS_EMU_LFSR_EN
  logic [7:0] r_lfsr;

  // Current LFSR state is the pixel for this href cycle; it steps after use.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_seed) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_href_next) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_fill = r_lfsr;
`else
  assign w_fill = i_frame_cnt;
`endif

  always_comb begin
    w_pix = 8'h00;
    case (i_pat)
      PAT_HRAMP: w_pix = i_x;
      PAT_VRAMP: w_pix = i_y;
      PAT_CHECK: w_pix = (i_x[4] ^ i_y[4]) ? 8'hFF : 8'h00;
      PAT_FRAME: w_pix = w_fill;
      default:   w_pix = 8'h00;
    endcase
  end

  assign o_data_next = i_href_next ? w_pix : 8'h00;

endmodule

// File: rtl/cmos_sensor_emu.sv
// rtl/cmos_sensor_emu.sv - DVP CMOS sensor emulator (vsync/href/data source)
//
// Purpose : generates frames with programmable geometry and test patterns.
//           Optional macro CMOS_EMU_LFSR_EN turns pattern 3 into an 8-bit LFSR.
// Ports   : clk_cmos    - pixel clock
//           rst         - asynchronous reset, active-high
//           enable      - run request, sampled only at frame boundaries
//           pattern_sel - 0 h-ramp, 1 v-ramp, 2 checkerboard, 3 frame fill/LFSR
//           dvp         - sensor bus (vsync/href/data), master side
//           frame_cnt   - completed frames, wraps at 16 bits
//           frame_done  - one-cycle pulse on the edge vsync falls
module cmos_sensor_emu
  import cmos_emu_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 370,
  parameter int V_ACTIVE = 724,
  parameter int VS_LEAD  = 100,
  parameter int VS_TAIL  = 100,
  parameter int V_BLANK  = 2000
) (
  input  logic                clk_cmos,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          pattern_sel,
  cmos_sensor_emu_if.master   dvp,
  output logic [15:0]         frame_cnt,
  output logic                frame_done
);

  // Down-counter reload values: a state lasting N cycles is entered with N-1.
  localparam logic [15:0] L_VS_LEAD  = 16'(VS_LEAD - 1);
  localparam logic [15:0] L_H_ACTIVE = 16'(H_ACTIVE - 1);
  localparam logic [15:0] L_H_BLANK  = 16'(H_BLANK - 1);
  localparam logic [15:0] L_VS_TAIL  = 16'(VS_TAIL - 1);
  localparam logic [15:0] L_V_BLANK  = 16'(V_BLANK - 1);
  localparam logic [15:0] Y_LAST     = 16'(V_ACTIVE - 1);

  emu_state_t  r_state, w_state_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic [15:0] r_x, w_x_next;
  logic [15:0] r_y, w_y_next;
  logic [1:0]  r_pat, w_pat_next;

  logic        r_vsync;
  logic        r_href;
  logic [7:0]  r_data;
  logic [15:0] r_frame_cnt;
  logic        r_frame_done;

  logic        w_cnt_zero;
  logic        w_vsync_next;
  logic        w_href_next;
  logic        w_vsync_fall;
  logic [7:0]  w_data_next;

  assign w_cnt_zero = (r_cnt == 16'd0);

  always_ff @(posedge clk_cmos or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_x     <= 16'd0;
      r_y     <= 16'd0;
      r_pat   <= PAT_HRAMP;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_pat   <= w_pat_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_pat_next   = r_pat;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_next = S_VS_LEAD;
          w_cnt_next   = L_VS_LEAD;
          w_pat_next   = pattern_sel;
        end
      end
      S_VS_LEAD: begin
        if (w_cnt_zero) begin
          w_state_next = S_LINE_ACT;
          w_cnt_next   = L_H_ACTIVE;
          w_x_next     = 16'd0;
          w_y_next     = 16'd0;
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      S_LINE_ACT: begin
        w_x_next = r_x + 16'd1;
        if (w_cnt_zero) begin
          // The last line goes straight to the tail; no line blank after it.
          if (r_y == Y_LAST) begin
            w_state_next = S_VS_TAIL;
            w_cnt_next   = L_VS_TAIL;
          end else begin
            w_state_next = S_LINE_BLANK;
            w_cnt_next   = L_H_BLANK;
          end
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      S_LINE_BLANK: begin
        if (w_cnt_zero) begin
          w_state_next = S_LINE_ACT;
          w_cnt_next   = L_H_ACTIVE;
          w_x_next     = 16'd0;
          w_y_next     = r_y + 16'd1;
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      S_VS_TAIL: begin
        if (w_cnt_zero) begin
          w_state_next = S_V_BLANK;
          w_cnt_next   = L_V_BLANK;
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      S_V_BLANK: begin
        if (w_cnt_zero) begin
          if (enable) begin
            w_state_next = S_VS_LEAD;
            w_cnt_next   = L_VS_LEAD;
            w_pat_next   = pattern_sel;
          end else begin
            w_state_next = S_IDLE;
            w_cnt_next   = 16'd0;
          end
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 16'd0;
      end
    endcase
  end

  // Bus outputs are registered copies of the current state's decode, so the
  // whole bus trails the FSM by one cycle and data stays aligned with href.
  assign w_vsync_next = (r_state == S_VS_LEAD)  || (r_state == S_LINE_ACT) ||
                        (r_state == S_LINE_BLANK) || (r_state == S_VS_TAIL);
  assign w_href_next  = (r_state == S_LINE_ACT);
  assign w_vsync_fall = r_vsync & ~w_vsync_next;

  cmos_emu_pattern_gen u_pattern_gen (
`ifdef CMOS_EMU_LFSR_EN
    .i_clk       (clk_cmos),
    .i_rst       (rst),
    .i_seed      (w_vsync_next & ~r_vsync),
`else
    .i_frame_cnt (r_frame_cnt[7:0]),
`endif
    .i_x         (r_x[7:0]),
    .i_y         (r_y[7:0]),
    .i_pat       (r_pat),
    .i_href_next (w_href_next),
    .o_data_next (w_data_next)
  );

  always_ff @(posedge clk_cmos or posedge rst) begin
    if (rst) begin
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_data       <= 8'h00;
      r_frame_cnt  <= 16'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_vsync      <= w_vsync_next;
      r_href       <= w_href_next;
      r_data       <= w_data_next;
      r_frame_done <= w_vsync_fall;
      if (w_vsync_fall) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign dvp.cmos_vsync = r_vsync;
  assign dvp.cmos_href  = r_href;
  assign dvp.cmos_data  = r_data;
  assign frame_cnt      = r_frame_cnt;
  assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_cmos_sensor_emu.sv
// tb/tb_cmos_sensor_emu.sv - directed self-checking bench for cmos_sensor_emu
module tb_cmos_sensor_emu;

  localparam int H_ACTIVE = 8;
  localparam int H_BLANK  = 4;
  localparam int V_ACTIVE = 3;
  localparam int VS_LEAD  = 5;
  localparam int VS_TAIL  = 2;
  localparam int V_BLANK  = 6;

  logic        clk_cmos = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] frame_cnt;
  logic        frame_done;

  int vectors     = 0;
  int miscompares = 0;

  // Per-frame observations filled in by capture()
  int         f_vs_len, f_bursts, f_bad_len, f_bad_data, f_bad_low;
  int         f_gap, f_gap_pulses, f_frame_pulses;
  logic       f_done_at_fall;
  logic [15:0] f_cnt_at_fall;
  logic [7:0] f_first_data;

  cmos_sensor_emu_if dvp ();

  cmos_sensor_emu #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_ACTIVE (V_ACTIVE),
    .VS_LEAD  (VS_LEAD),
    .VS_TAIL  (VS_TAIL),
    .V_BLANK  (V_BLANK)
  ) dut (
    .clk_cmos    (clk_cmos),
    .rst         (rst),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .dvp         (dvp.master),
    .frame_cnt   (frame_cnt),
    .frame_done  (frame_done)
  );

  always #5 clk_cmos = ~clk_cmos;

  task automatic tick();
    @(posedge clk_cmos);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef CMOS_EMU_LFSR_EN
  function automatic logic [7:0] model_lfsr(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction
`endif

  // Waits for vsync to rise, then walks the frame cycle by cycle until vsync
  // falls; the sample it returns on is the first vsync-low cycle.
  task automatic capture(input int pat, input logic [7:0] fill, input int drop_line,
                         input logic [1:0] next_pat);
    int guard;
    int pos;
    logic prev;
    logic [7:0] lf;
    logic [7:0] expd;
    f_vs_len = 0; f_bursts = 0; f_bad_len = 0; f_bad_data = 0; f_bad_low = 0;
    f_gap = 0; f_gap_pulses = 0; f_frame_pulses = 0; f_first_data = 8'h00;
    guard = 0;
    while (dvp.cmos_vsync !== 1'b1 && guard < 300) begin
      f_gap++;
      if (frame_done === 1'b1) f_gap_pulses++;
      tick();
      guard++;
    end
    if (guard >= 300) begin
      chk("vsync_rise_timeout", 32'(dvp.cmos_vsync), 32'd1);
      return;
    end
    lf = 8'hA5; pos = 0; prev = 1'b0; guard = 0;
    while (dvp.cmos_vsync === 1'b1 && guard < 500) begin
      f_vs_len++;
      if (frame_done === 1'b1) f_frame_pulses++;
      if (dvp.cmos_href === 1'b1) begin
        if (!prev) begin
          pos = 0;
          if (f_bursts == drop_line) enable = 1'b0;
          if (f_bursts == 0) pattern_sel = next_pat;
        end
        case (pat)
          0:       expd = 8'(pos);
          1:       expd = 8'(f_bursts);
          2:       expd = (((pos ^ f_bursts) & 16) != 0) ? 8'hFF : 8'h00;
`ifdef CMOS_EMU_LFSR_EN
          default: expd = lf;
`else
          default: expd = fill;
`endif
        endcase
        if (f_bursts == 0 && pos == 0) f_first_data = dvp.cmos_data;
        if (dvp.cmos_data !== expd) f_bad_data++;
`ifdef CMOS_EMU_LFSR_EN
        lf = model_lfsr(lf);
`endif
        pos++;
        prev = 1'b1;
      end else begin
        if (dvp.cmos_data !== 8'h00) f_bad_low++;
        if (prev) begin
          if (pos != H_ACTIVE) f_bad_len++;
          f_bursts++;
        end
        prev = 1'b0;
      end
      tick();
      guard++;
    end
    if (guard >= 500) chk("vsync_fall_timeout", 32'(dvp.cmos_vsync), 32'd0);
    f_done_at_fall = frame_done;
    f_cnt_at_fall  = frame_cnt;
  endtask

  // vsync high = 5 + 3*8 + 2*4 + 2 = 39 cycles
  task automatic check_frame(input string tag, input int exp_cnt);
    chk({tag, ".vs_len"},       32'(f_vs_len),       32'd39);
    chk({tag, ".bursts"},       32'(f_bursts),       32'd3);
    chk({tag, ".burst_len"},    32'(f_bad_len),      32'd0);
    chk({tag, ".data"},         32'(f_bad_data),     32'd0);
    chk({tag, ".data_low"},     32'(f_bad_low),      32'd0);
    chk({tag, ".done_in_frm"},  32'(f_frame_pulses), 32'd0);
    chk({tag, ".done_at_fall"}, 32'(f_done_at_fall), 32'd1);
    chk({tag, ".cnt_at_fall"},  32'(f_cnt_at_fall),  32'(exp_cnt));
  endtask

  initial begin
    int act;
    int guard;
    rst = 1'b1;
    enable = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) tick();
    chk("rst.vsync",      32'(dvp.cmos_vsync), 32'd0);
    chk("rst.href",       32'(dvp.cmos_href),  32'd0);
    chk("rst.data",       32'(dvp.cmos_data),  32'd0);
    chk("rst.frame_cnt",  32'(frame_cnt),      32'd0);
    chk("rst.frame_done", 32'(frame_done),     32'd0);
    rst = 1'b0;
    tick();

    // Continuous run; pattern_sel changes mid-frame only take effect next frame
    enable = 1'b1;
    pattern_sel = 2'd0;
    capture(0, 8'h00, -1, 2'd1);
    check_frame("f1", 1);
    capture(1, 8'h00, -1, 2'd2);
    check_frame("f2", 2);
    chk("f2.gap",        32'(f_gap),        32'd6);
    chk("f2.gap_pulses", 32'(f_gap_pulses), 32'd1);
    // Frame 3: checkerboard, enable dropped during line 1
    capture(2, 8'h00, 1, 2'd2);
    check_frame("f3", 3);
    chk("f3.gap",        32'(f_gap),        32'd6);
    chk("f3.gap_pulses", 32'(f_gap_pulses), 32'd1);
    act = 0;
    repeat (20) begin
      if (dvp.cmos_vsync !== 1'b0 || dvp.cmos_href !== 1'b0 || dvp.cmos_data !== 8'h00) act++;
      tick();
    end
    chk("idle.activity",  32'(act),       32'd0);
    chk("idle.frame_cnt", 32'(frame_cnt), 32'd3);

    // Pattern 3 over two back-to-back frames
    enable = 1'b1;
    pattern_sel = 2'd3;
    capture(3, 8'h03, -1, 2'd3);
    check_frame("f4", 4);
`ifdef CMOS_EMU_LFSR_EN
    chk("f4.first", 32'(f_first_data), 32'hA5);
`else
    chk("f4.first", 32'(f_first_data), 32'h03);
`endif
    capture(3, 8'h04, 0, 2'd3);
    check_frame("f5", 5);
    chk("f5.gap", 32'(f_gap), 32'd6);
`ifdef CMOS_EMU_LFSR_EN
    chk("f5.first", 32'(f_first_data), 32'hA5);
`else
    chk("f5.first", 32'(f_first_data), 32'h04);
`endif
    repeat (12) tick();

    // Asynchronous reset in the middle of a line
    pattern_sel = 2'd0;
    enable = 1'b1;
    guard = 0;
    while (dvp.cmos_href !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    chk("mid.href_seen", 32'(dvp.cmos_href), 32'd1);
    repeat (3) tick();
    #3 rst = 1'b1;
    #1;
    chk("mid.vsync",      32'(dvp.cmos_vsync), 32'd0);
    chk("mid.href",       32'(dvp.cmos_href),  32'd0);
    chk("mid.data",       32'(dvp.cmos_data),  32'd0);
    chk("mid.frame_cnt",  32'(frame_cnt),      32'd0);
    chk("mid.frame_done", 32'(frame_done),     32'd0);
    repeat (2) @(posedge clk_cmos);
    #2 rst = 1'b0;
    tick();
    chk("restart.latency", 32'(dvp.cmos_vsync), 32'd0);
    capture(0, 8'h00, 0, 2'd0);
    check_frame("f6", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
